dmem_responder: RTL

Data-memory responder for the RISC-V datapath: the memory-side end of the load/store interface. It accepts one request at a time from the core over a valid/ready handshake. It applies a programmable number of wait states, performs a byte, halfword or word access on an internal word array, and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory wherever the core is driven by a stall-capable memory port.

---
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-request valid/ready load/store port onto a word array with programmable wait states.
// Optional misaligned-access trapping is compiled in with `define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the producer holds its payload until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [2:0]  l_funct3;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          bad_f3;
    logic          misaligned;
    logic          acc_err;
    logic          access;
    logic          do_write;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign dbg_state = state;
    assign idx       = l_addr[AW+1:2];
    assign access    = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        out_of_range = ({2'b00, l_addr[31:2]} >= 32'(DEPTH_WORDS));
        if (l_we)
            bad_f3 = (l_funct3 > 3'd2);
        else
            bad_f3 = (l_funct3 == 3'd3) || (l_funct3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = ((l_funct3[1:0] == 2'd1) && l_addr[0]) ||
                     ((l_funct3[1:0] == 2'd2) && (l_addr[1:0] != 2'd0));
`else
        // Untrapped misalignment is absorbed by lane selection ignoring the low address bits.
        misaligned = 1'b0;
`endif
        acc_err  = out_of_range || bad_f3 || misaligned;
        do_write = access && l_we && !acc_err;
    end

    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{l_addr[1:0], 3'b000} +: 8];
        rd_half = l_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (l_funct3)
            3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_data = rd_word;
            3'd4:    load_data = {24'd0, rd_byte};
            3'd5:    load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        case (l_funct3[1:0])
            2'd0: begin
                be = 4'b0001 << l_addr[1:0];
                wd = {4{l_wdata[7:0]}};
            end
            2'd1: begin
                be = l_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{l_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = l_wdata;
            end
        endcase
    end

    // The array deliberately has no reset; only qualified stores touch it.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            l_we      <= 1'b0;
            l_addr    <= 32'd0;
            l_wdata   <= 32'd0;
            l_funct3  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        l_we      <= req_we;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        l_funct3  <= req_funct3;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || l_we) ? 32'd0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
